// File: rtl/usb_transaction_ctrl.sv
// Device-side USB transaction sequencer: walks token/data/handshake phases,
// keeps per-endpoint data toggles and turnaround timeouts, and drives FIFO commits.

package types;
  typedef enum logic [3:0] {
    PID_RSVD  = 4'b0000,
    PID_OUT   = 4'b0001,
    PID_ACK   = 4'b0010,
    PID_DATA0 = 4'b0011,
    PID_PING  = 4'b0100,
    PID_SOF   = 4'b0101,
    PID_NYET  = 4'b0110,
    PID_DATA2 = 4'b0111,
    PID_SPLIT = 4'b1000,
    PID_IN    = 4'b1001,
    PID_NAK   = 4'b1010,
    PID_DATA1 = 4'b1011,
    PID_PRE   = 4'b1100,
    PID_SETUP = 4'b1101,
    PID_STALL = 4'b1110,
    PID_MDATA = 4'b1111
  } pid_t;

  localparam bit USB_FULL_SPEED = 1'b1;
endpackage

module usb_transaction_ctrl #(
  parameter int NUM_ENDP = 4,
  parameter int TIMEOUT  = 600
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                usb_reset,
  input  logic [6:0]          dev_addr,
  input  logic                rx_pid_valid,
  input  logic [3:0]          rx_pid,
  input  logic [6:0]          rx_addr,
  input  logic [3:0]          rx_endp,
  input  logic                rx_crc5_ok,
  input  logic                rx_data_done,
  input  logic                rx_crc16_ok,
  input  logic [NUM_ENDP-1:0] ep_stall,
  input  logic [NUM_ENDP-1:0] ep_in_ready,
  input  logic [NUM_ENDP-1:0] ep_out_full,
  output logic                tx_req,
  output logic [3:0]          tx_pid,
  input  logic                tx_ack,
  output logic [3:0]          cur_endp,
  output logic                out_commit,
  output logic                out_discard,
  output logic                in_commit,
  output logic                setup_flag,
  output logic                sof,
  output logic                token_done,
  output logic [3:0]          err
);
  import types::*;

  localparam int              EW          = (NUM_ENDP > 1) ? $clog2(NUM_ENDP) : 1;
  localparam int              TW          = $clog2(TIMEOUT + 1);
  localparam logic [4:0]      LP_NUM_ENDP = 5'(NUM_ENDP);
  localparam logic [TW-1:0]   LP_TIMEOUT  = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DATA, S_RECV_DATA, S_SEND_HS, S_SEND_DATA, S_WAIT_HS
  } state_t;

  state_t              r_state,     w_state_nxt;
  logic [3:0]          r_endp,      w_endp_nxt;
  logic [NUM_ENDP-1:0] r_toggle,    w_toggle_nxt;
  logic [TW-1:0]       r_timer,     w_timer_nxt;
  logic                r_tok_setup, w_tok_setup_nxt;
  logic                r_data1,     w_data1_nxt;
  pid_t                r_tx_pid,    w_tx_pid_nxt;
  logic                r_out_commit, w_out_commit;
  logic                r_out_discard, w_out_discard;
  logic                r_in_commit, w_in_commit;
  logic                r_setup_flag, w_setup_flag;
  logic                r_sof,       w_sof;
  logic                r_token_done, w_token_done;
  logic [3:0]          r_err,       w_err;

  logic          w_clear;
  pid_t          w_rx_pid;
  logic          w_is_token;
  logic          w_tok_ok;
  logic [EW-1:0] w_rx_ep;
  logic [EW-1:0] w_cur_ep;
  logic          w_timeout;
  logic [TW-1:0] w_timer_inc;

  assign w_clear     = reset | usb_reset;
  assign w_rx_pid    = pid_t'(rx_pid);
  assign w_is_token  = (w_rx_pid == PID_OUT) || (w_rx_pid == PID_IN) || (w_rx_pid == PID_SETUP);
  assign w_tok_ok    = rx_pid_valid && w_is_token && rx_crc5_ok && (rx_addr == dev_addr) &&
                       ({1'b0, rx_endp} < LP_NUM_ENDP);
  assign w_rx_ep     = rx_endp[EW-1:0];
  assign w_cur_ep    = r_endp[EW-1:0];
  assign w_timeout   = (r_timer == LP_TIMEOUT);
  assign w_timer_inc = w_timeout ? r_timer : r_timer + TW'(1);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_endp_nxt      = r_endp;
    w_toggle_nxt    = r_toggle;
    w_timer_nxt     = '0;
    w_tok_setup_nxt = r_tok_setup;
    w_data1_nxt     = r_data1;
    w_tx_pid_nxt    = r_tx_pid;
    w_out_commit    = 1'b0;
    w_out_discard   = 1'b0;
    w_in_commit     = 1'b0;
    w_setup_flag    = 1'b0;
    w_sof           = 1'b0;
    w_token_done    = 1'b0;
    w_err           = 4'b0000;   // {bto, crc16, crc5, pid}

    unique case (r_state)
      S_IDLE: begin
        if (rx_pid_valid && (w_is_token || w_rx_pid == PID_SOF) && !rx_crc5_ok) begin
          w_err[1] = 1'b1;
        end else if (w_tok_ok) begin
          w_endp_nxt      = rx_endp;
          w_tok_setup_nxt = (w_rx_pid == PID_SETUP);
          if (w_rx_pid != PID_IN) begin
            w_state_nxt = S_WAIT_DATA;
          end else if (ep_stall[w_rx_ep]) begin
            w_state_nxt  = S_SEND_HS;
            w_tx_pid_nxt = PID_STALL;
          end else if (ep_in_ready[w_rx_ep]) begin
            w_state_nxt  = S_SEND_DATA;
            w_tx_pid_nxt = r_toggle[w_rx_ep] ? PID_DATA1 : PID_DATA0;
          end else begin
            w_state_nxt  = S_SEND_HS;
            w_tx_pid_nxt = PID_NAK;
          end
        end else if (rx_pid_valid && w_rx_pid == PID_SOF) begin
          w_sof = 1'b1;
        end
      end

      S_WAIT_DATA: begin
        w_timer_nxt = w_timer_inc;
        if (rx_pid_valid) begin
          if (w_rx_pid == PID_DATA0 || w_rx_pid == PID_DATA1) begin
            w_state_nxt = S_RECV_DATA;
            w_data1_nxt = (w_rx_pid == PID_DATA1);
          end else begin
            w_state_nxt = S_IDLE;
            w_err[0]    = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_err[3]    = 1'b1;
        end
      end

      S_RECV_DATA: begin
        if (rx_data_done) begin
          w_state_nxt  = S_SEND_HS;
          w_tx_pid_nxt = PID_ACK;
          if (!rx_crc16_ok) begin
            w_state_nxt   = S_IDLE;
            w_tx_pid_nxt  = r_tx_pid;
            w_out_discard = 1'b1;
            w_err[2]      = 1'b1;
          end else if (r_tok_setup) begin
            // SETUP must always be accepted, even on a halted or full endpoint.
            if (!r_data1) begin
              w_out_commit           = 1'b1;
              w_setup_flag           = 1'b1;
              w_toggle_nxt[w_cur_ep] = 1'b1;
            end else begin
              w_state_nxt   = S_IDLE;
              w_tx_pid_nxt  = r_tx_pid;
              w_out_discard = 1'b1;
              w_err[0]      = 1'b1;
            end
          end else if (ep_stall[w_cur_ep]) begin
            w_tx_pid_nxt  = PID_STALL;
            w_out_discard = 1'b1;
          end else if (r_data1 != r_toggle[w_cur_ep]) begin
            w_out_discard = 1'b1;   // host missed our ACK and resent: re-ACK, drop copy
          end else if (ep_out_full[w_cur_ep]) begin
            w_tx_pid_nxt  = PID_NAK;
            w_out_discard = 1'b1;
          end else begin
            w_out_commit           = 1'b1;
            w_toggle_nxt[w_cur_ep] = ~r_toggle[w_cur_ep];
          end
        end
      end

      S_SEND_HS: begin
        if (tx_ack) begin
          w_state_nxt  = S_IDLE;
          w_token_done = 1'b1;
        end
      end

      S_SEND_DATA: begin
        if (tx_ack) begin
          w_state_nxt = S_WAIT_HS;
        end
      end

      S_WAIT_HS: begin
        w_timer_nxt = w_timer_inc;
        if (rx_pid_valid) begin
          w_state_nxt = S_IDLE;
          if (w_rx_pid == PID_ACK) begin
            w_in_commit            = 1'b1;
            w_token_done           = 1'b1;
            w_toggle_nxt[w_cur_ep] = ~r_toggle[w_cur_ep];
          end else begin
            w_err[0] = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_err[3]    = 1'b1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state       <= S_IDLE;
      r_endp        <= '0;
      r_toggle      <= '0;
      r_timer       <= '0;
      r_tok_setup   <= 1'b0;
      r_data1       <= 1'b0;
      r_tx_pid      <= PID_ACK;
      r_out_commit  <= 1'b0;
      r_out_discard <= 1'b0;
      r_in_commit   <= 1'b0;
      r_setup_flag  <= 1'b0;
      r_sof         <= 1'b0;
      r_token_done  <= 1'b0;
      r_err         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_endp        <= w_endp_nxt;
      r_toggle      <= w_toggle_nxt;
      r_timer       <= w_timer_nxt;
      r_tok_setup   <= w_tok_setup_nxt;
      r_data1       <= w_data1_nxt;
      r_tx_pid      <= w_tx_pid_nxt;
      r_out_commit  <= w_out_commit;
      r_out_discard <= w_out_discard;
      r_in_commit   <= w_in_commit;
      r_setup_flag  <= w_setup_flag;
      r_sof         <= w_sof;
      r_token_done  <= w_token_done;
      r_err         <= w_err;
    end
  end

  assign tx_req      = (r_state == S_SEND_HS) || (r_state == S_SEND_DATA);
  assign tx_pid      = r_tx_pid;
  assign cur_endp    = r_endp;
  assign out_commit  = r_out_commit;
  assign out_discard = r_out_discard;
  assign in_commit   = r_in_commit;
  assign setup_flag  = r_setup_flag;
  assign sof         = r_sof;
  assign token_done  = r_token_done;
  assign err         = r_err;

endmodule

// File: tb/tb_usb_transaction_ctrl.sv
// Self-checking bench for usb_transaction_ctrl: directed protocol scenarios plus
// randomized transactions predicted by a transaction-level toggle/handshake model.

module tb_usb_transaction_ctrl;
  import types::*;

  localparam int NUM_ENDP = 4;
  localparam int TIMEOUT  = 600;

  logic                clk = 1'b0;
  logic                reset, usb_reset;
  logic [6:0]          dev_addr, rx_addr;
  logic                rx_pid_valid, rx_crc5_ok, rx_data_done, rx_crc16_ok;
  logic [3:0]          rx_pid, rx_endp;
  logic [NUM_ENDP-1:0] ep_stall, ep_in_ready, ep_out_full;
  logic                tx_req, tx_ack;
  logic [3:0]          tx_pid, cur_endp, err;
  logic                out_commit, out_discard, in_commit, setup_flag, sof, token_done;

  usb_transaction_ctrl #(.NUM_ENDP(NUM_ENDP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .usb_reset(usb_reset), .dev_addr(dev_addr),
    .rx_pid_valid(rx_pid_valid), .rx_pid(rx_pid), .rx_addr(rx_addr), .rx_endp(rx_endp),
    .rx_crc5_ok(rx_crc5_ok), .rx_data_done(rx_data_done), .rx_crc16_ok(rx_crc16_ok),
    .ep_stall(ep_stall), .ep_in_ready(ep_in_ready), .ep_out_full(ep_out_full),
    .tx_req(tx_req), .tx_pid(tx_pid), .tx_ack(tx_ack), .cur_endp(cur_endp),
    .out_commit(out_commit), .out_discard(out_discard), .in_commit(in_commit),
    .setup_flag(setup_flag), .sof(sof), .token_done(token_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse counters, sampled on the falling edge.
  int c_oc = 0, c_od = 0, c_ic = 0, c_sf = 0, c_sof = 0, c_td = 0;
  int c_err [4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    if (out_commit)  c_oc++;
    if (out_discard) c_od++;
    if (in_commit)   c_ic++;
    if (setup_flag)  c_sf++;
    if (sof)         c_sof++;
    if (token_done)  c_td++;
    for (int b = 0; b < 4; b++) if (err[b]) c_err[b]++;
  end

  // Reference model: the data toggle each endpoint currently expects/sends.
  bit model_tog [NUM_ENDP];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_pid(input pid_t p, input logic [6:0] a, input int e, input bit crc5);
    rx_pid_valid = 1'b1;
    rx_pid       = p;
    rx_addr      = a;
    rx_endp      = 4'(e);
    rx_crc5_ok   = crc5;
    tick();
    rx_pid_valid = 1'b0;
    rx_crc5_ok   = 1'b0;
  endtask

  function automatic int total_pulses();
    return c_oc + c_od + c_ic + c_sf + c_sof + c_td;
  endfunction

  // One full transaction; expectations come from the protocol rules applied to the model.
  task automatic do_txn(input pid_t kind, input int e, input bit stall, input bit ready,
                        input bit full, input bit dpid1, input bit crc_ok, input bit host_ack,
                        input string tag);
    int   s_oc, s_od, s_ic, s_sf, s_td, s_pid, s_crc16;
    bit   exp_tx, is_data;
    pid_t exp_pid;
    int   x_oc, x_od, x_ic, x_sf, x_td, x_pid, x_crc16;
    bit   new_tog;

    s_oc = c_oc; s_od = c_od; s_ic = c_ic; s_sf = c_sf; s_td = c_td;
    s_pid = c_err[0]; s_crc16 = c_err[2];
    exp_tx = 0; is_data = 0; exp_pid = PID_ACK; new_tog = model_tog[e];
    x_oc = 0; x_od = 0; x_ic = 0; x_sf = 0; x_td = 0; x_pid = 0; x_crc16 = 0;

    if (kind == PID_IN) begin
      exp_tx = 1;
      if (stall)      begin exp_pid = PID_STALL; x_td = 1; end
      else if (ready) begin
        is_data = 1;
        exp_pid = model_tog[e] ? PID_DATA1 : PID_DATA0;
        if (host_ack) begin x_ic = 1; x_td = 1; new_tog = !model_tog[e]; end
        else x_pid = 1;
      end else        begin exp_pid = PID_NAK; x_td = 1; end
    end else if (!crc_ok) begin
      x_od = 1; x_crc16 = 1;
    end else if (kind == PID_SETUP) begin
      if (!dpid1) begin exp_tx = 1; x_oc = 1; x_sf = 1; x_td = 1; new_tog = 1; end
      else        begin x_od = 1; x_pid = 1; end
    end else begin
      exp_tx = 1; x_td = 1;
      if (stall)                   begin exp_pid = PID_STALL; x_od = 1; end
      else if (dpid1 != model_tog[e]) x_od = 1;
      else if (full)               begin exp_pid = PID_NAK; x_od = 1; end
      else                         begin x_oc = 1; new_tog = !model_tog[e]; end
    end

    ep_stall    = NUM_ENDP'($urandom); ep_stall[e]    = stall;
    ep_in_ready = NUM_ENDP'($urandom); ep_in_ready[e] = ready;
    ep_out_full = NUM_ENDP'($urandom); ep_out_full[e] = full;

    send_pid(kind, dev_addr, e, 1'b1);
    if (kind != PID_IN) begin
      repeat ($urandom_range(1, 3)) tick();
      send_pid(dpid1 ? PID_DATA1 : PID_DATA0, 7'd0, 0, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
      rx_data_done = 1'b1;
      rx_crc16_ok  = crc_ok;
      tick();
      rx_data_done = 1'b0;
    end

    n_checks++;
    if (tx_req !== exp_tx) begin
      n_fail++; $display("FAIL %s tx_req: got %b expected %b", tag, tx_req, exp_tx);
    end
    if (exp_tx) begin
      n_checks++;
      if (tx_pid !== exp_pid) begin
        n_fail++; $display("FAIL %s tx_pid: got %h expected %h", tag, tx_pid, exp_pid);
      end
      repeat ($urandom_range(0, 3)) tick();
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      n_checks++;
      if (tx_req !== 1'b0) begin
        n_fail++; $display("FAIL %s tx_req_drop: got %b expected 0", tag, tx_req);
      end
      if (is_data) begin
        repeat ($urandom_range(0, 3)) tick();
        send_pid(host_ack ? PID_ACK : PID_DATA0, 7'd0, 0, 1'b0);
      end
    end
    repeat (2) tick();

    n_checks++;
    if ((c_oc - s_oc) != x_oc || (c_od - s_od) != x_od || (c_ic - s_ic) != x_ic ||
        (c_sf - s_sf) != x_sf || (c_td - s_td) != x_td) begin
      n_fail++;
      $display("FAIL %s pulses oc/od/ic/sf/td: got %0d%0d%0d%0d%0d expected %0d%0d%0d%0d%0d",
               tag, c_oc - s_oc, c_od - s_od, c_ic - s_ic, c_sf - s_sf, c_td - s_td,
               x_oc, x_od, x_ic, x_sf, x_td);
    end
    n_checks++;
    if ((c_err[0] - s_pid) != x_pid || (c_err[2] - s_crc16) != x_crc16) begin
      n_fail++;
      $display("FAIL %s err pid/crc16: got %0d/%0d expected %0d/%0d", tag,
               c_err[0] - s_pid, c_err[2] - s_crc16, x_pid, x_crc16);
    end
    model_tog[e] = new_tog;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < NUM_ENDP; i++) model_tog[i] = 0;
    n_checks++;
    if (tx_req !== 1'b0 || tx_pid !== PID_ACK || cur_endp !== 4'd0) begin
      n_fail++; $display("FAIL reset_outputs: got req=%b pid=%h endp=%0d expected 0/%h/0",
                         tx_req, tx_pid, cur_endp, PID_ACK);
    end
    n_checks++;
    if ({out_commit, out_discard, in_commit, setup_flag, sof, token_done, err} !== 10'd0) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 0",
                         {out_commit, out_discard, in_commit, setup_flag, sof, token_done, err});
    end
  endtask

  task automatic test_in_toggle();
    do_txn(PID_IN, 1, 0, 1, 0, 0, 1, 1, "in_first_data0");
    do_txn(PID_IN, 1, 0, 1, 0, 0, 1, 1, "in_second_data1");
  endtask

  task automatic test_out_retry();
    do_txn(PID_OUT, 2, 0, 0, 0, 0, 1, 0, "out_data0");
    do_txn(PID_OUT, 2, 0, 0, 0, 0, 1, 0, "out_resend");
    do_txn(PID_OUT, 2, 0, 0, 0, 1, 1, 0, "out_data1");
    do_txn(PID_OUT, 2, 0, 0, 1, 0, 1, 0, "out_full_nak");
  endtask

  task automatic test_setup();
    do_txn(PID_SETUP, 0, 1, 0, 1, 0, 1, 0, "setup_stalled_full");
    do_txn(PID_IN,    0, 0, 1, 0, 0, 1, 1, "in_after_setup");
    do_txn(PID_SETUP, 0, 0, 0, 0, 1, 1, 0, "setup_data1");
  endtask

  task automatic test_nak_stall();
    do_txn(PID_IN,  3, 0, 0, 0, 0, 1, 1, "in_nak");
    do_txn(PID_IN,  3, 1, 1, 0, 0, 1, 1, "in_stall");
    do_txn(PID_OUT, 3, 1, 0, 0, 0, 1, 0, "out_stall");
    do_txn(PID_OUT, 3, 0, 0, 0, 0, 0, 0, "out_crc16_bad");
  endtask

  task automatic test_ignored();
    int s_all, s_e1, s_other, s_sof;
    bit saw;
    s_all = total_pulses(); s_e1 = c_err[1]; s_other = c_err[0] + c_err[2] + c_err[3];
    ep_stall = '0; ep_in_ready = '1;

    send_pid(PID_IN, 7'd6, 1, 1'b1);
    saw = 0; repeat (4) begin saw |= tx_req; tick(); end
    n_checks++;
    if (saw) begin n_fail++; $display("FAIL addr_mismatch: got tx_req=1 expected 0"); end

    send_pid(PID_IN, dev_addr, 1, 1'b0);
    saw = 0; repeat (4) begin saw |= tx_req; tick(); end
    n_checks++;
    if (saw) begin n_fail++; $display("FAIL crc5_bad_txreq: got tx_req=1 expected 0"); end
    n_checks++;
    if ((c_err[1] - s_e1) != 1) begin
      n_fail++; $display("FAIL crc5_bad_err: got %0d crc5 pulses expected 1", c_err[1] - s_e1);
    end

    send_pid(PID_IN, dev_addr, NUM_ENDP, 1'b1);
    saw = 0; repeat (4) begin saw |= tx_req; tick(); end
    n_checks++;
    if (saw) begin n_fail++; $display("FAIL endp_range: got tx_req=1 expected 0"); end

    tx_ack = 1'b1; tick(); tx_ack = 1'b0; repeat (2) tick();
    n_checks++;
    if (total_pulses() != s_all || (c_err[0] + c_err[2] + c_err[3]) != s_other) begin
      n_fail++; $display("FAIL ignored_side_effects: got %0d extra pulses expected 0",
                         total_pulses() - s_all + c_err[0] + c_err[2] + c_err[3] - s_other);
    end

    s_sof = c_sof;
    send_pid(PID_SOF, 7'd0, 0, 1'b1);
    tick();
    n_checks++;
    if ((c_sof - s_sof) != 1) begin
      n_fail++; $display("FAIL sof_pulse: got %0d expected 1", c_sof - s_sof);
    end
  endtask

  task automatic test_timeout();
    int   s_bto, s_ic, s_td, k;
    pid_t exp_pid;
    bit   saw;
    ep_stall = '0; ep_in_ready = '1;
    exp_pid = model_tog[1] ? PID_DATA1 : PID_DATA0;
    send_pid(PID_IN, dev_addr, 1, 1'b1);
    n_checks++;
    if (tx_req !== 1'b1 || tx_pid !== exp_pid) begin
      n_fail++; $display("FAIL bto_in_data: got req=%b pid=%h expected 1/%h", tx_req, tx_pid, exp_pid);
    end
    s_bto = c_err[3]; s_ic = c_ic; s_td = c_td;
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    k = 0;
    while (c_err[3] == s_bto && k < TIMEOUT + 20) begin tick(); k++; end
    n_checks++;
    if ((c_err[3] - s_bto) != 1) begin
      n_fail++; $display("FAIL in_bto: got %0d bto pulses expected 1", c_err[3] - s_bto);
    end
    n_checks++;
    if (k < TIMEOUT || k > TIMEOUT + 2) begin
      n_fail++; $display("FAIL in_bto_latency: got %0d cycles expected %0d..%0d", k, TIMEOUT, TIMEOUT + 2);
    end
    n_checks++;
    if (c_ic != s_ic || c_td != s_td) begin
      n_fail++; $display("FAIL in_bto_side: got in_commit=%0d token_done=%0d expected 0/0",
                         c_ic - s_ic, c_td - s_td);
    end
    do_txn(PID_IN, 1, 0, 1, 0, 0, 1, 1, "in_retry_same_pid");

    s_bto = c_err[3];
    send_pid(PID_OUT, dev_addr, 2, 1'b1);
    k = 0; saw = 0;
    while (c_err[3] == s_bto && k < TIMEOUT + 20) begin saw |= tx_req; tick(); k++; end
    n_checks++;
    if ((c_err[3] - s_bto) != 1 || saw) begin
      n_fail++; $display("FAIL out_bto: got %0d bto pulses tx_req=%b expected 1/0", c_err[3] - s_bto, saw);
    end
    tick();
  endtask

  task automatic test_usb_reset();
    if (!model_tog[1]) do_txn(PID_IN, 1, 0, 1, 0, 0, 1, 1, "in_prep");
    ep_stall = '0; ep_in_ready = '1;
    send_pid(PID_IN, dev_addr, 1, 1'b1);
    n_checks++;
    if (tx_req !== 1'b1 || tx_pid !== PID_DATA1) begin
      n_fail++; $display("FAIL usbrst_pre: got req=%b pid=%h expected 1/%h", tx_req, tx_pid, PID_DATA1);
    end
    usb_reset = 1'b1; tick(); usb_reset = 1'b0;
    for (int i = 0; i < NUM_ENDP; i++) model_tog[i] = 0;
    n_checks++;
    if (tx_req !== 1'b0 || cur_endp !== 4'd0 || tx_pid !== PID_ACK) begin
      n_fail++; $display("FAIL usbrst_outputs: got req=%b endp=%0d pid=%h expected 0/0/%h",
                         tx_req, cur_endp, tx_pid, PID_ACK);
    end
    do_txn(PID_IN,  1, 0, 1, 0, 0, 1, 1, "usbrst_in_data0");
    do_txn(PID_OUT, 2, 0, 0, 0, 0, 1, 0, "usbrst_out_data0");
  endtask

  task automatic test_random();
    pid_t kind;
    int   r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 4);
      kind = (r < 2) ? PID_IN : (r < 4) ? PID_OUT : PID_SETUP;
      do_txn(kind, $urandom_range(0, NUM_ENDP - 1), $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 5) != 0, $urandom_range(0, 4) != 0, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; usb_reset = 1'b0; dev_addr = 7'd5;
    rx_pid_valid = 1'b0; rx_pid = PID_RSVD; rx_addr = '0; rx_endp = '0;
    rx_crc5_ok = 1'b0; rx_data_done = 1'b0; rx_crc16_ok = 1'b0;
    ep_stall = '0; ep_in_ready = '0; ep_out_full = '0; tx_ack = 1'b0;
    tick();
    test_reset();
    test_in_toggle();
    test_out_retry();
    test_setup();
    test_nak_stall();
    test_ignored();
    test_timeout();
    test_usb_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_transaction_ctrl.md
Name: usb_transaction_ctrl

Overview:
- Device-side protocol sequencer for the USB SIE; uses the `types` package (`pid_t`, `USB_FULL_SPEED`).
- Consumes decoded packets from the packet receiver and decides each transaction's phase: token, data, handshake.
- Issues transmit requests (DATA0/DATA1/ACK/NAK/STALL) to the packet transmitter.
- Keeps per-endpoint data toggles and bus-turnaround timeouts, and tells the endpoint FIFOs when to commit.

Parameters:
- NUM_ENDP, 4, number of endpoints supported (endpoints 0..NUM_ENDP-1).
- TIMEOUT, 600, bus-turnaround timeout in clk cycles; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- usb_reset  input  1  bus reset detected (SE0); same effect as reset on this block
- dev_addr  input  7  assigned device address
- rx_pid_valid  input  1  one-cycle strobe: PID (plus token fields for tokens) decoded
- rx_pid  input  4  pid_t of the received packet
- rx_addr  input  7  token address, valid with rx_pid_valid
- rx_endp  input  4  token endpoint, valid with rx_pid_valid
- rx_crc5_ok  input  1  token CRC5 good, valid with rx_pid_valid
- rx_data_done  input  1  one-cycle strobe: end of data packet
- rx_crc16_ok  input  1  CRC16 good, valid with rx_data_done
- ep_stall  input  NUM_ENDP  per-endpoint halt
- ep_in_ready  input  NUM_ENDP  per-endpoint IN data available
- ep_out_full  input  NUM_ENDP  per-endpoint OUT buffer cannot accept
- tx_req  output  1  transmit request; level, held until tx_ack
- tx_pid  output  4  pid_t to transmit; stable while tx_req=1
- tx_ack  input  1  transmitter finished packet (one-cycle)
- cur_endp  output  4  endpoint of the current transaction
- out_commit  output  1  pulse: accept received OUT/SETUP data into cur_endp
- out_discard  output  1  pulse: drop received data
- in_commit  output  1  pulse: host ACKed IN data, advance cur_endp FIFO
- setup_flag  output  1  pulse with out_commit when the data stage followed SETUP
- sof  output  1  pulse on valid SOF
- token_done  output  1  pulse at end of any handshake-completed transaction
- err  output  4  one-cycle pulses {bto, crc16, crc5, pid}

Behaviour:
- Reset/usb_reset:
  - state IDLE, all toggles 0 (expect/send DATA0).
  - tx_req=0, tx_pid=ACK, cur_endp=0, timer=0.
  - All pulse outputs 0.
- A token is accepted when all hold: rx_pid_valid, pid ∈ {OUT, IN, SETUP}, rx_crc5_ok, rx_addr==dev_addr, rx_endp<NUM_ENDP.
- IDLE:
  - Accepted token latches cur_endp.
  - OUT/SETUP -> WAIT_DATA, timer cleared.
  - IN with ep_stall[e] -> SEND_HS(STALL); IN with ep_in_ready[e] -> SEND_DATA; otherwise IN -> SEND_HS(NAK).
  - SOF with crc5 ok pulses sof.
  - Any token with bad CRC5 pulses err.crc5 and is ignored.
  - Address or endpoint mismatch is silently ignored.
- WAIT_DATA:
  - DATA0/DATA1 pid -> RECV_DATA, with the pid latched.
  - Any other pid -> IDLE with err.pid.
  - timer==TIMEOUT -> IDLE with err.bto.
- RECV_DATA: on rx_data_done:
  - Bad CRC16: out_discard, err.crc16, IDLE, no handshake.
  - SETUP with DATA0: ack regardless of stall/full; out_commit and setup_flag; toggle[e]=1.
  - SETUP with DATA1: out_discard, err.pid, IDLE.
  - OUT with ep_stall: STALL, out_discard.
  - OUT with toggle mismatch (retransmission): ACK, out_discard, toggle unchanged.
  - OUT with ep_out_full: NAK, out_discard.
  - OUT otherwise: ACK, out_commit, toggle[e] flips.
  - All handshake cases -> SEND_HS.
- SEND_HS:
  - tx_req=1 with the chosen pid.
  - On tx_ack: tx_req=0 next cycle, token_done, IDLE.
- SEND_DATA:
  - tx_pid = toggle[e] ? DATA1 : DATA0.
  - On tx_ack -> WAIT_HS, timer cleared.
- WAIT_HS:
  - rx_pid_valid with ACK: in_commit, toggle[e] flips, token_done, IDLE.
  - Any other pid -> IDLE, no flip, err.pid.
  - Timeout -> IDLE, no flip, err.bto.
- Timer: increments only in WAIT_DATA/WAIT_HS; saturates at TIMEOUT.
- Event precedence:
  - rx strobes are ignored in SEND_HS/SEND_DATA.
  - tx_ack outside a SEND state is ignored.
  - Same-cycle rx strobe and timeout: the strobe wins.
- Priority: reset > usb_reset > everything; a mid-transaction reset drops tx_req the next cycle.
- Latency:
  - Token strobe -> tx_req asserts after 1 cycle (IN).
  - rx_data_done -> tx_req asserts after 1 cycle.

Test Plan:
- dev_addr=5: IN token addr 5 endp 1, ep_in_ready[1]=1 -> tx_pid=DATA0. Host ACK -> in_commit, token_done. Repeat -> DATA1.
- OUT endp 2 with DATA0 and good CRC16, not full -> ACK, out_commit. Resend the same DATA0 -> ACK, out_discard, toggle still 1.
- SETUP endp 0 with DATA0, ep_stall[0]=1 -> ACK, out_commit, setup_flag. Following IN uses DATA1.
- IN with ep_in_ready=0 -> NAK. IN with ep_stall=1 -> STALL. Token addr 6 -> no tx_req; bad CRC5 -> err.crc5 only.
- IN data sent, no host response for TIMEOUT cycles -> err.bto, no toggle flip; retry sends the same DATAx.
- OUT data with crc16 bad -> err.crc16, no tx_req. usb_reset during SEND_DATA -> tx_req=0 next cycle, toggles cleared.
